// File: rtl/seqgen_pkg.sv
// Shared types and defaults for the serial sequence generator and the detector benches.
// The PAR state is only reachable when the generator is built with PARITY_BIT_EN defined.
package seqgen_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SHIFT = 3'd1,
    PAR   = 3'd2,
    GAP   = 3'd3,
    DONE  = 3'd4
  } state_e;

  localparam int DEF_WIDTH      = 8;
  localparam int DEF_GAP_CYCLES = 2;
  localparam int DEF_REP_W      = 4;

endpackage

// File: rtl/seqgen_shift_reg.sv
// WIDTH-bit parallel-load, shift-left register with MSB tap and async active-low clear.
module seqgen_shift_reg
  import seqgen_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_en,
  input  logic [WIDTH-1:0] load_val,
  input  logic             shift_en,
  output logic             msb
);

  logic [WIDTH-1:0] shreg_q;
  logic [WIDTH-1:0] shreg_d;

  // Load wins over shift so a pattern reload on the last bit takes effect.
  always_comb begin
    shreg_d = shreg_q;
    if (load_en) begin
      shreg_d = load_val;
    end else if (shift_en) begin
      shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shreg_q <= '0;
    end else begin
      shreg_q <= shreg_d;
    end
  end

  assign msb = shreg_q[WIDTH-1];

endmodule

// File: rtl/moore_sequence_generator.sv
// Moore FSM shifting a loaded pattern out MSB-first, repeated with idle gaps.
// Optional even-parity bit after each pattern copy: define PARITY_BIT_EN.
module moore_sequence_generator
  import seqgen_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int GAP_CYCLES = DEF_GAP_CYCLES,
  parameter int REP_W      = DEF_REP_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  input  logic [REP_W-1:0] rep_in,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             serial_out,
  output logic             frame_active,
  output logic             done
);

  // Handshake: a frame is accepted on a rising clk edge where load_valid and
  // load_ready are both high; load_ready is high only in IDLE, so requests
  // made during a frame are simply dropped, never queued.

  localparam int BW = $clog2(WIDTH);
  localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
  localparam logic [GW-1:0] GAP_LAST = (GAP_CYCLES > 0) ? GW'(GAP_CYCLES - 1) : '0;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic [REP_W-1:0] rep_q, rep_d;
  logic [BW-1:0]    bitcnt_q, bitcnt_d;
  logic [GW-1:0]    gapcnt_q, gapcnt_d;

  logic             sh_load;
  logic             sh_shift;
  logic [WIDTH-1:0] sh_load_val;
  logic             sh_msb;
  logic             pattern_end;

  seqgen_shift_reg #(.WIDTH(WIDTH)) u_shreg (
    .clk      (clk),
    .rst      (rst),
    .load_en  (sh_load),
    .load_val (sh_load_val),
    .shift_en (sh_shift),
    .msb      (sh_msb)
  );

  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    rep_d       = rep_q;
    bitcnt_d    = bitcnt_q;
    gapcnt_d    = gapcnt_q;
    sh_load     = 1'b0;
    sh_shift    = 1'b0;
    sh_load_val = hold_q;
    pattern_end = 1'b0;
    case (state_q)
      IDLE: begin
        if (load_valid) begin
          hold_d      = data_in;
          rep_d       = rep_in;
          bitcnt_d    = '0;
          sh_load     = 1'b1;
          sh_load_val = data_in;
          state_d     = SHIFT;
        end
      end
      SHIFT: begin
        sh_shift = 1'b1;
        if (bitcnt_q == BIT_LAST) begin
`ifdef PARITY_BIT_EN
          state_d = PAR;
`else
          pattern_end = 1'b1;
`endif
        end else begin
          bitcnt_d = bitcnt_q + 1'b1;
        end
      end
`ifdef PARITY_BIT_EN
      PAR: pattern_end = 1'b1;
`endif
      GAP: begin
        if (gapcnt_q == GAP_LAST) begin
          gapcnt_d = '0;
          state_d  = SHIFT;
        end else begin
          gapcnt_d = gapcnt_q + 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Shared end-of-copy handling: either reload the held pattern for the
    // next repetition or finish the frame.
    if (pattern_end) begin
      if (rep_q != '0) begin
        rep_d       = rep_q - 1'b1;
        bitcnt_d    = '0;
        sh_load     = 1'b1;
        sh_load_val = hold_q;
        state_d     = (GAP_CYCLES == 0) ? SHIFT : GAP;
      end else begin
        state_d = DONE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      hold_q   <= '0;
      rep_q    <= '0;
      bitcnt_q <= '0;
      gapcnt_q <= '0;
    end else begin
      state_q  <= state_d;
      hold_q   <= hold_d;
      rep_q    <= rep_d;
      bitcnt_q <= bitcnt_d;
      gapcnt_q <= gapcnt_d;
    end
  end

  // Outputs depend only on registered state and the shift register.
  always_comb begin
    serial_out   = 1'b0;
    frame_active = 1'b0;
    done         = 1'b0;
    load_ready   = 1'b0;
    case (state_q)
      IDLE: load_ready = 1'b1;
      SHIFT: begin
        serial_out   = sh_msb;
        frame_active = 1'b1;
      end
`ifdef PARITY_BIT_EN
      PAR: begin
        serial_out   = ^hold_q;
        frame_active = 1'b1;
      end
`endif
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_moore_sequence_generator.sv
// Bench for moore_sequence_generator: directed frames, reset abort, random frames,
// all checked cycle by cycle against a per-cycle expected-output queue.
module tb_moore_sequence_generator;
  import seqgen_pkg::*;

  localparam int WIDTH      = 8;
  localparam int GAP_CYCLES = 2;
  localparam int REP_W      = 4;
`ifdef PARITY_BIT_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [WIDTH-1:0] data_in = '0;
  logic [REP_W-1:0] rep_in = '0;
  logic             load_valid = 1'b0;
  logic             load_ready;
  logic             serial_out;
  logic             frame_active;
  logic             done;

  int checks   = 0;
  int failures = 0;

  // Expected {serial_out, frame_active, done, load_ready} per cycle after accept.
  logic [3:0] exp_q[$];

  moore_sequence_generator #(
    .WIDTH(WIDTH), .GAP_CYCLES(GAP_CYCLES), .REP_W(REP_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .data_in      (data_in),
    .rep_in       (rep_in),
    .load_valid   (load_valid),
    .load_ready   (load_ready),
    .serial_out   (serial_out),
    .frame_active (frame_active),
    .done         (done)
  );

  // Clock/reset: posedges at 5,15,...; inputs driven and outputs sampled on negedges.
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] outs();
    return {serial_out, frame_active, done, load_ready};
  endfunction

  // Reference model: each copy is WIDTH bits MSB first (+ parity), gaps between copies, then a done cycle.
  task automatic build_expected(input logic [WIDTH-1:0] data, input int rep);
    for (int r = 0; r <= rep; r++) begin
      for (int b = WIDTH - 1; b >= 0; b--) exp_q.push_back({data[b], 3'b100});
      if (P == 1) exp_q.push_back({^data, 3'b100});
      if (r < rep) for (int g = 0; g < GAP_CYCLES; g++) exp_q.push_back(4'b0000);
    end
    exp_q.push_back(4'b0010);
  endtask

  // Driver + scoreboard for one frame. hold_valid keeps load_valid high with all-ones data mid-frame.
  task automatic run_frame(input string name, input logic [WIDTH-1:0] data, input int rep,
                           input bit hold_valid, output int y_cycles);
    int cyc;
    int run;
    logic [3:0] e;
    y_cycles = 0;
    run = 0;
    cyc = 1;
    @(negedge clk);
    check({name, " ready_before"}, 32'(load_ready), 32'd1);
    data_in = data;
    rep_in = REP_W'(rep);
    load_valid = 1'b1;
    build_expected(data, rep);
    @(negedge clk);
    if (hold_valid) begin
      data_in = '1;
    end else begin
      load_valid = 1'b0;
      data_in = WIDTH'($urandom);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check($sformatf("%s cyc%0d", name, cyc), 32'(outs()), 32'(e));
      run = serial_out ? run + 1 : 0;
      if (run >= 3) y_cycles++;
      cyc++;
      @(negedge clk);
    end
    load_valid = 1'b0;
    check({name, " ready_after"}, 32'(outs()), 32'h1);
  endtask

  initial begin
    int y;
    int rep;
    logic [WIDTH-1:0] d;

    // Reset state.
    #2;
    check("reset_outs", 32'(outs()), 32'h1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("idle_outs", 32'(outs()), 32'h1);

    // Single copy, then three copies with gaps, then ignored mid-frame load requests.
    run_frame("t1_e0", 8'b1110_0000, 0, 1'b0, y);
    run_frame("t2_a5", 8'hA5, 2, 1'b0, y);
    run_frame("t3_hold", 8'h3C, 1, 1'b1, y);

    // Reset in cycle 4 of an F0 frame aborts at once with no done pulse.
    @(negedge clk);
    data_in = 8'hF0;
    rep_in = '0;
    load_valid = 1'b1;
    @(negedge clk);
    load_valid = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      check($sformatf("t4 cyc%0d", c), 32'(outs()), 32'hC);
      @(negedge clk);
    end
    check("t4 cyc4", 32'(outs()), 32'hC);
    #2 rst = 1'b0;
    #1 check("t4 async_abort", 32'(outs()), 32'h1);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("t4 held_reset", 32'(outs()), 32'h1);
    end
    rst = 1'b1;
    @(negedge clk);
    check("t4 released", 32'(outs()), 32'h1);
    run_frame("t4_restart", 8'h5A, 0, 1'b0, y);

    // Parity case (parity bit present only in the PARITY_BIT_EN build).
    run_frame("t5_07", 8'b0000_0111, 0, 1'b0, y);

    // A 111-detector on the stream sees 01111000 as exactly two detections.
    run_frame("t6_78", 8'b0111_1000, 0, 1'b0, y);
    check("t6 det_cycles", 32'(y), 32'd2);

    // Back-to-back boundary: all-ones pattern with maximum repeats.
    run_frame("t7_ff", 8'hFF, (1 << REP_W) - 1, 1'b0, y);

    // Randomized frames with random idle spacing.
    for (int i = 0; i < 8; i++) begin
      d = WIDTH'($urandom);
      rep = int'($urandom_range(0, 3));
      repeat ($urandom_range(0, 3)) @(negedge clk);
      run_frame($sformatf("rnd%0d", i), d, rep, bit'($urandom_range(0, 1)), y);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
